// File: rtl/matrix_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : matrix_mult_seq
// Brief    : Sequential NxN matrix multiplier, one MAC per cycle, with
//            signed/unsigned operands and saturate/wrap result conversion.
// Revision : 1.0
// ============================================================================
module matrix_mult_seq #(
    parameter int N      = 3,
    parameter int DW     = 16,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N*N*DW-1:0]   A_flat,
    input  logic [N*N*DW-1:0]   B_flat,
    output logic                busy,
    output logic                done,
    output logic [N*N*DW-1:0]   R_flat,
    output logic                ovf
);
    localparam int MW   = N * N * DW;
    localparam int ACCW = 2 * DW + $clog2(N);
    localparam int IW   = $clog2(N);
    localparam logic [IW-1:0] c_LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   a_q, a_d, b_q, b_d;
    logic [MW-1:0]   shadow_q, shadow_d, r_q, r_d;
    logic [IW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic            ovf_sh_q, ovf_sh_d, ovf_q, ovf_d;

    logic [DW-1:0]   w_a, w_b, w_res;
    logic [ACCW-1:0] w_a_ext, w_b_ext, w_sum;
    logic            w_fits;
    int              w_a_idx, w_b_idx, w_r_idx;

    // MAC datapath and per-element range conversion of the running sum
    always_comb begin
        w_a_idx = int'(i_q) * N + int'(k_q);
        w_b_idx = int'(k_q) * N + int'(j_q);
        w_r_idx = int'(i_q) * N + int'(j_q);
        w_a     = a_q[w_a_idx*DW +: DW];
        w_b     = b_q[w_b_idx*DW +: DW];
        if (SIGNED != 0) begin
            w_a_ext = {{(ACCW-DW){w_a[DW-1]}}, w_a};
            w_b_ext = {{(ACCW-DW){w_b[DW-1]}}, w_b};
        end else begin
            w_a_ext = {{(ACCW-DW){1'b0}}, w_a};
            w_b_ext = {{(ACCW-DW){1'b0}}, w_b};
        end
        w_sum = acc_q + w_a_ext * w_b_ext;
        if (SIGNED != 0) begin
            w_fits = (&w_sum[ACCW-1:DW-1]) | ~(|w_sum[ACCW-1:DW-1]);
        end else begin
            w_fits = ~(|w_sum[ACCW-1:DW]);
        end
        w_res = w_sum[DW-1:0];
        if ((SAT != 0) && !w_fits) begin
            if (SIGNED != 0) begin
                w_res = w_sum[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
            end else begin
                w_res = '1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        shadow_d = shadow_q;
        r_d      = r_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        acc_d    = acc_q;
        ovf_sh_d = ovf_sh_q;
        ovf_d    = ovf_q;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                done    = (state_q == S_DONE);
                state_d = S_IDLE;
                if (start) begin
                    a_d      = A_flat;
                    b_d      = B_flat;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    acc_d    = '0;
                    ovf_sh_d = 1'b0;
                    state_d  = S_MAC;
                end
            end
            S_MAC: begin
                busy = 1'b1;
                if (k_q == c_LAST) begin
                    shadow_d[w_r_idx*DW +: DW] = w_res;
                    ovf_sh_d = ovf_sh_q | ~w_fits;
                    acc_d    = '0;
                    k_d      = '0;
                    if (j_q == c_LAST) begin
                        j_d = '0;
                        if (i_q == c_LAST) begin
                            i_d     = '0;
                            state_d = S_FIN;
                        end else begin
                            i_d = i_q + IW'(1);
                        end
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end else begin
                    acc_d = w_sum;
                    k_d   = k_q + IW'(1);
                end
            end
            S_FIN: begin
                // Results become visible only here so R_flat never shows a partial matrix
                busy    = 1'b1;
                r_d     = shadow_q;
                ovf_d   = ovf_sh_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            r_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            ovf_sh_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            r_q      <= r_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            ovf_sh_q <= ovf_sh_d;
            ovf_q    <= ovf_d;
        end
    end

    assign R_flat = r_q;
    assign ovf    = ovf_q;

endmodule
`default_nettype wire
